// File: rtl/demosaic_pkg.sv
// Shared types and defaults for the demosaic frame buffer.
// ADDR_W is always derived from the maximum frame size.
package demosaic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PROC,
        DRAIN
    } fb_state_e;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_MAX_WIDTH  = 1024;
    localparam int unsigned DEF_MAX_HEIGHT = 512;
    localparam int unsigned DEF_NUM_CH     = 3;
    localparam int unsigned DEF_DIM_W      = 11;

    function automatic int unsigned fb_addr_w(input int unsigned w, input int unsigned h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port memory: combinational read, synchronous write.
// Contents are intentionally not reset.
module fb_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/demosaic_frame_buffer.sv
// Frame buffer around the demosaic core: streams a Bayer frame in, serves the
// core's image/channel ports, then drains all channels as one packed stream.
module demosaic_frame_buffer
    import demosaic_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned MAX_WIDTH  = DEF_MAX_WIDTH,
    parameter int unsigned MAX_HEIGHT = DEF_MAX_HEIGHT,
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned DIM_W      = DEF_DIM_W,
    localparam int unsigned ADDR_W    = fb_addr_w(MAX_WIDTH, MAX_HEIGHT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DIM_W-1:0]         width,
    input  logic [DIM_W-1:0]         height,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     core_start,
    input  logic [ADDR_W-1:0]        img_addr,
    output logic [DATA_W-1:0]        data_in,
    input  logic [NUM_CH-1:0]        ch_wr,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH*DATA_W-1:0] ch_rdata,
    input  logic                     core_done,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err_size
);

    localparam int unsigned DEPTH = MAX_WIDTH * MAX_HEIGHT;
    localparam int unsigned CNT_W = ADDR_W + 1;

    fb_state_e state_q, state_d;

    logic [CNT_W-1:0]         n_q, load_cnt_q, rd_cnt_q;
    logic                     core_start_q, out_valid_q, out_last_q, err_size_q;
    logic [NUM_CH*DATA_W-1:0] out_data_q;
    logic                     size_bad, accept, xfer, out_load;
    logic [CNT_W-1:0]         n_new;
    logic [ADDR_W-1:0]        img_ram_addr;

    assign size_bad = (width == '0) || (height == '0) ||
                      (32'(width) > MAX_WIDTH) || (32'(height) > MAX_HEIGHT);
    assign n_new    = CNT_W'(width) * CNT_W'(height);

    assign in_ready = (state_q == LOAD) && (load_cnt_q < n_q);
    assign accept   = in_ready && in_valid;
    assign xfer     = out_valid_q && out_ready;
    // Prime the output register on DRAIN entry, then refill on every non-final transfer.
    assign out_load = (state_q == DRAIN) && (!out_valid_q || (xfer && !out_last_q));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && !size_bad) state_d = LOAD;
            LOAD:    if (accept && (load_cnt_q == n_q - CNT_W'(1))) state_d = PROC;
            PROC:    if (core_done) state_d = DRAIN;
            DRAIN:   if (xfer && out_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            load_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            err_size_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= (state_q == LOAD) && (state_d == PROC);
            if ((state_q == IDLE) && start) begin
                if (size_bad) begin
                    err_size_q <= 1'b1;
                end else begin
                    err_size_q <= 1'b0;
                    n_q        <= n_new;
                    load_cnt_q <= '0;
                end
            end
            if (accept) begin
                load_cnt_q <= load_cnt_q + CNT_W'(1);
            end
            if (state_q == PROC) begin
                rd_cnt_q <= '0;
            end
            if (out_load) begin
                out_data_q  <= ch_rdata;
                out_last_q  <= (rd_cnt_q == n_q - CNT_W'(1));
                rd_cnt_q    <= rd_cnt_q + CNT_W'(1);
                out_valid_q <= 1'b1;
            end else if (xfer) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign img_ram_addr = (state_q == LOAD) ? load_cnt_q[ADDR_W-1:0] : img_addr;

    fb_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_img_ram (
        .clk   (clk),
        .we    (accept),
        .addr  (img_ram_addr),
        .wdata (in_data),
        .rdata (data_in)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ADDR_W-1:0] addr;
        logic              we;
        // Outside PROC the channel memories are addressed by the drain counter.
        assign addr = (state_q == PROC) ? ch_addr[c*ADDR_W +: ADDR_W] : rd_cnt_q[ADDR_W-1:0];
        assign we   = ch_wr[c] && (state_q == PROC);

        fb_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_ch_ram (
            .clk   (clk),
            .we    (we),
            .addr  (addr),
            .wdata (ch_wdata[c*DATA_W +: DATA_W]),
            .rdata (ch_rdata[c*DATA_W +: DATA_W])
        );
    end

    assign core_start = core_start_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_data_q;
    assign err_size   = err_size_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_demosaic_frame_buffer.sv
// Randomised bench for demosaic_frame_buffer with a frame-level reference model
// (pixel arrays plus an expected output-beat queue).
module tb_demosaic_frame_buffer;
    import demosaic_pkg::*;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned NUM_CH     = 3;
    localparam int unsigned DIM_W      = 11;
    localparam int unsigned MAX_WIDTH  = 1024;
    localparam int unsigned MAX_HEIGHT = 512;
    localparam int unsigned ADDR_W     = fb_addr_w(MAX_WIDTH, MAX_HEIGHT);
    localparam int unsigned OW         = NUM_CH * DATA_W;

    logic                     clk, reset, start, in_valid, in_ready, core_start;
    logic [DIM_W-1:0]         width, height;
    logic [DATA_W-1:0]        in_data, data_in;
    logic [ADDR_W-1:0]        img_addr;
    logic [NUM_CH-1:0]        ch_wr;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [OW-1:0]            ch_wdata, ch_rdata, out_data;
    logic                     core_done, out_valid, out_ready, out_last, busy, err_size;

    demosaic_frame_buffer #(
        .DATA_W     (DATA_W),
        .MAX_WIDTH  (MAX_WIDTH),
        .MAX_HEIGHT (MAX_HEIGHT),
        .NUM_CH     (NUM_CH),
        .DIM_W      (DIM_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .width      (width),
        .height     (height),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .core_start (core_start),
        .img_addr   (img_addr),
        .data_in    (data_in),
        .ch_wr      (ch_wr),
        .ch_addr    (ch_addr),
        .ch_wdata   (ch_wdata),
        .ch_rdata   (ch_rdata),
        .core_done  (core_done),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .err_size   (err_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] img_m [2048];
    logic [DATA_W-1:0] chm   [NUM_CH][2048];
    logic [OW:0]       exp_q [$];
    int                frame_beats, cs_count;
    logic [OW-1:0]     first_beat, last_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output stream checker: every transfer against the model queue, plus stall stability.
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    logic          prev_last;
    always @(negedge clk) begin
        logic [OW:0] e;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (core_start) cs_count++;
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e[OW-1:0]);
                    check("beat_last", out_last, e[OW]);
                    if (frame_beats == 0) first_beat = out_data;
                    last_beat = out_data;
                    frame_beats++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic do_start(input int w, input int h);
        start  = 1'b1;
        width  = DIM_W'(w);
        height = DIM_W'(h);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic rand_ch_bus();
        for (int c = 0; c < NUM_CH; c++) begin
            ch_addr[c*ADDR_W +: ADDR_W]  = ADDR_W'($urandom_range(0, 63));
            ch_wdata[c*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
    endtask

    // mode: 0 = out_ready held, 1 = 1,0,0,1 pattern, 2 = random
    task automatic run_frame(input int w, input int h, input int mode, input bit fixed_pat,
                             input bit glitch);
        int            n, idx, guard, cyc;
        logic          acc, lst;
        logic [OW-1:0] word;
        n = w * h;
        for (int i = 0; i < n; i++) img_m[i] = fixed_pat ? DATA_W'(32'h10 + i) : DATA_W'($urandom);
        do_start(w, h);
        check("start_busy", busy, 1);
        check("start_err_clear", err_size, 0);
        frame_beats = 0;
        cs_count    = 0;

        idx = 0;
        guard = 0;
        while (idx < n && guard < 8 * n + 16) begin
            in_valid  = fixed_pat ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_data   = in_valid ? img_m[idx] : DATA_W'($urandom);
            core_done = glitch && (guard == 0);
            ch_wr     = glitch ? '1 : '0;
            rand_ch_bus();
            #1;
            check("in_ready_load", in_ready, 1);
            @(posedge clk);
            acc = in_valid;
            #1;
            if (acc) idx++;
            guard++;
        end
        in_valid  = 1'b0;
        core_done = 1'b0;
        ch_wr     = '0;
        check("load_complete", idx, n);
        check("in_ready_after_load", in_ready, 0);
        check("core_start_pulse", core_start, 1);

        if (fixed_pat && n > 5) begin
            img_addr = ADDR_W'(5);
            #2;
            check("data_in_lit", data_in, 8'h15);
        end
        for (int k = 0; k < 3; k++) begin
            img_addr = ADDR_W'($urandom_range(0, n - 1));
            #1;
            check("data_in", data_in, img_m[img_addr]);
        end
        @(posedge clk); #1;
        check("core_start_once", core_start, 0);

        if (glitch) begin
            start    = 1'b1;
            width    = DIM_W'(2);
            height   = DIM_W'(2);
            in_valid = 1'b1;
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = 1'b0;
            check("start_in_proc_busy", busy, 1);
            check("start_in_proc_ready", in_ready, 0);
        end

        for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] v [NUM_CH];
            bit                done_c [NUM_CH];
            int                left;
            for (int c = 0; c < NUM_CH; c++) begin
                v[c]      = fixed_pat ? DATA_W'(c * 32'h40 + i) : DATA_W'($urandom);
                done_c[c] = 1'b0;
            end
            left = NUM_CH;
            while (left > 0) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    ch_wr[c] = !done_c[c] && (fixed_pat || ($urandom_range(0, 1) == 1));
                    ch_addr[c*ADDR_W +: ADDR_W] = ch_wr[c] ? ADDR_W'(i)
                                                           : ADDR_W'($urandom_range(0, n - 1));
                    ch_wdata[c*DATA_W +: DATA_W] = ch_wr[c] ? v[c] : DATA_W'($urandom);
                end
                @(posedge clk); #1;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_wr[c] && !done_c[c]) begin
                        done_c[c]  = 1'b1;
                        chm[c][i]  = v[c];
                        left--;
                    end
                end
            end
        end
        ch_wr = '0;

        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NUM_CH; c++)
                ch_addr[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, n - 1));
            #1;
            for (int c = 0; c < NUM_CH; c++)
                check("ch_rdata", ch_rdata[c*DATA_W +: DATA_W], chm[c][ch_addr[c*ADDR_W +: ADDR_W]]);
        end

        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NUM_CH; c++) word[c*DATA_W +: DATA_W] = chm[c][i];
            lst = (i == n - 1);
            exp_q.push_back({lst, word});
        end

        core_done = 1'b1;
        in_valid  = 1'b1;
        in_data   = DATA_W'($urandom);
        @(posedge clk); #1;
        core_done = 1'b0;
        check("drain_first_idle", out_valid, 0);
        check("drain_busy", busy, 1);

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40 * n + 40) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            ch_wr = glitch ? '1 : '0;
            rand_ch_bus();
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) check("out_valid_rise", out_valid, 1);
            check("in_ready_drain", in_ready, 0);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        out_ready = 1'b0;
        ch_wr     = '0;
        in_valid  = 1'b0;
        check("end_out_valid", out_valid, 0);
        check("end_busy", busy, 0);
        check("frame_beats", frame_beats, n);
        check("core_start_count", cs_count, 1);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        width     = '0;
        height    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        img_addr  = '0;
        ch_wr     = '0;
        ch_addr   = '0;
        ch_wdata  = '0;
        core_done = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_core_start", core_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err_size", err_size, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_frame(4, 2, 0, 1'b1, 1'b0);
        check("first_beat_lit", first_beat, 24'h804000);
        check("last_beat_lit", last_beat, 24'h874707);
        run_frame(4, 2, 1, 1'b0, 1'b1);

        do_start(1025, 2);
        check("err_wide", err_size, 1);
        check("err_wide_busy", busy, 0);
        do_start(4, 0);
        check("err_h0", err_size, 1);
        check("err_h0_busy", busy, 0);
        do_start(0, 3);
        check("err_w0", err_size, 1);
        do_start(2, 513);
        check("err_tall", err_size, 1);
        check("err_tall_busy", busy, 0);
        run_frame(2, 2, 1, 1'b0, 1'b0);

        do_start(4, 2);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("mid_load_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("rst_edge_busy", busy, 0);
        check("rst_edge_in_ready", in_ready, 0);
        check("rst_edge_out_valid", out_valid, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        run_frame(4, 2, 2, 1'b0, 1'b1);

        run_frame(1, 1, 1, 1'b0, 1'b0);
        run_frame(1024, 1, 2, 1'b0, 1'b0);
        run_frame(1, 512, 0, 1'b0, 1'b1);
        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(1, 12), $urandom_range(1, 6), $urandom_range(0, 2), 1'b0,
                      ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demosaic_frame_buffer.md
Name: demosaic_frame_buffer

Overview:
- Parametrised frame-buffer and stream adapter around the demosaic core.
- Loads a Bayer frame from a valid/ready input stream into an internal image memory, serves the core's combinational image read port and its per-channel read/write ports, then drains all channel memories as one packed valid/ready output stream.
- Generalises the fixed 3-channel, 8-bit, queue-fed test wrapper into a synthesizable block with configurable pixel width, maximum frame size and channel count, plus size checking and backpressure.

Parameters:
- DATA_W, 8, pixel bit width.
- MAX_WIDTH, 1024, maximum frame width in pixels.
- MAX_HEIGHT, 512, maximum frame height in pixels.
- NUM_CH, 3, number of output channel memories.
- DIM_W, 11, bit width of the width and height inputs.
- ADDR_W, $clog2(MAX_WIDTH*MAX_HEIGHT) (19), pixel address width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that starts a frame; sampled only in IDLE.
- width  in  DIM_W  frame width; captured on an accepted start.
- height  in  DIM_W  frame height; captured on an accepted start.
- in_valid  in  1  input pixel valid.
- in_data  in  DATA_W  Bayer pixel, raster order.
- in_ready  out  1  input pixel accepted when in_valid and in_ready are both high.
- core_start  out  1  one-cycle pulse to the core when the load completes.
- img_addr  in  ADDR_W  core image read address.
- data_in  out  DATA_W  image memory at img_addr, combinational.
- ch_wr  in  NUM_CH  per-channel write enables from the core.
- ch_addr  in  NUM_CH*ADDR_W  per-channel addresses, packed, channel 0 in the LSBs.
- ch_wdata  in  NUM_CH*DATA_W  per-channel write data, packed.
- ch_rdata  out  NUM_CH*DATA_W  channel memory at ch_addr, combinational.
- core_done  in  1  core finished; level or pulse.
- out_valid  out  1  output pixel valid.
- out_data  out  NUM_CH*DATA_W  packed pixel for all channels, channel 0 in the LSBs.
- out_ready  in  1  output transfer occurs when out_valid and out_ready are both high.
- out_last  out  1  high together with the final output pixel.
- busy  out  1  high in any state other than IDLE.
- err_size  out  1  sticky flag for a rejected size; cleared by the next accepted start.

Behaviour:
- Reset values: in_ready, core_start, out_valid, out_last, busy and err_size are 0; out_data is 0; FSM is IDLE; all counters are 0. Memory contents are not cleared by reset.
- FSM states are IDLE, LOAD, PROC and DRAIN.
- IDLE:
  - On start with width==0, height==0, width>MAX_WIDTH or height>MAX_HEIGHT, set err_size and stay in IDLE.
  - Otherwise capture N = width*height (ADDR_W+1 bits), clear err_size and go to LOAD.
- LOAD:
  - in_ready is 1 while load_cnt < N.
  - Each accepted pixel is written to img_mem[load_cnt] and load_cnt increments.
  - The cycle that accepts pixel N-1 drops in_ready on the next edge, pulses core_start on the next cycle and moves to PROC.
- PROC:
  - data_in = img_mem[img_addr] and ch_rdata[c] = chmem[c][ch_addr[c]], both combinational.
  - When ch_wr[c] is high, chmem[c][ch_addr[c]] is written at the clock edge. Writes to different channels in the same cycle are independent.
  - core_done high moves the FSM to DRAIN.
- DRAIN:
  - rd_cnt starts at 0. out_data is a register loaded with {chmem[NUM_CH-1][rd_cnt] .. chmem[0][rd_cnt]}.
  - out_valid first rises 1 cycle after entering DRAIN.
  - While out_valid && !out_ready, out_data and out_last are held stable.
  - On each transfer the register reloads the next index in the same cycle, so there are no bubbles under constant out_ready.
  - out_last is high with index N-1. The transfer of that pixel moves the FSM to IDLE, with out_valid low on the next cycle.
- Ignored events:
  - start while busy.
  - core_done outside PROC.
  - ch_wr outside PROC (no memory write).
  - in_valid outside LOAD (in_ready is 0).
- data_in and ch_rdata stay combinational in every state. Their values are only meaningful in PROC.
- Reset asserted mid-frame returns to IDLE immediately (asynchronous) and drops all outputs to reset values. The partial frame is discarded.
- Address arithmetic: raster index = row*width + col, computed by the core. The buffer uses only linear counters, and counters never wrap beyond N.

Decomposition:
- Shared package demosaic_pkg:
  - state enum fb_state_e {IDLE, LOAD, PROC, DRAIN};
  - default DATA_W, MAX_WIDTH, MAX_HEIGHT and NUM_CH constants;
  - localparam function computing ADDR_W.
- One sub-module, fb_ram: single-port memory with combinational read and synchronous write, parameters DATA_W and DEPTH. Instantiate it NUM_CH+1 times, once for the image and once per channel. The drain path muxes its address over ch_addr when not in PROC.

Test Plan:
- width=4, height=2, start, stream 8 pixels 0x10..0x17 with in_valid held high -> in_ready low after 8th beat; core_start pulses exactly once; img_addr=5 gives data_in=0x15.
- Same frame, core writes ch0[i]=i, ch1[i]=0x40+i, ch2[i]=0x80+i, then core_done -> 8 beats out_data={0x80+i,0x40+i,i}; out_last only on i=7; busy=0 afterwards.
- DRAIN with out_ready toggling 1,0,0,1 per cycle -> out_data and out_last are stable during stalls, no pixel is lost or duplicated, and beats 0..7 arrive in order.
- start with width=1025 or height=0 -> err_size=1, busy stays 0; next valid start (width=2, height=2) clears err_size.
- Reset driven low after 3 of 8 input beats -> next edge shows IDLE, in_ready=0, busy=0; a new full frame then completes correctly.
- start pulsed during PROC and core_done pulsed during LOAD -> both ignored; FSM sequence unchanged.
